// File: rtl/word_serializer_pkg.sv
// Shared types and helpers for the word serializer: FSM state encoding and a
// counter-width helper that never returns zero.
package word_serializer_pkg;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  // $clog2 of 1 is 0, which would give a zero-width counter.
  function automatic int clog2_safe(input int w);
    int r;
    r = $clog2(w);
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/word_serializer.sv
// Parallel-to-serial converter with one holding register in front of the
// shifter, so back-to-back words stream at one bit per clock with no bubble.
import word_serializer_pkg::*;

module word_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             word_last,
  output logic             busy
);

  localparam int CNT_W = clog2_safe(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t             state_q, state_d;
  logic               hold_full_q, hold_full_d;
  logic [WIDTH-1:0]   hold_q, hold_d;
  logic [WIDTH-1:0]   shift_reg_q, shift_reg_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;

  logic               accept;
  logic               at_last;
  logic [WIDTH-1:0]   shifted;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      hold_full_q <= 1'b0;
      hold_q      <= '0;
      shift_reg_q <= '0;
      bit_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      hold_full_q <= hold_full_d;
      hold_q      <= hold_d;
      shift_reg_q <= shift_reg_d;
      bit_cnt_q   <= bit_cnt_d;
    end
  end

  // in_ready comes only from a flop, so upstream sees no path from in_valid.
  assign in_ready = !hold_full_q;
  assign accept   = in_valid && in_ready;
  assign at_last  = (state_q == S_SHIFT) && (bit_cnt_q == LAST_CNT);
  assign shifted  = MSB_FIRST ? {shift_reg_q[WIDTH-2:0], 1'b0}
                              : {1'b0, shift_reg_q[WIDTH-1:1]};

  always_comb begin
    state_d     = state_q;
    hold_full_d = hold_full_q;
    hold_d      = hold_q;
    shift_reg_d = shift_reg_q;
    bit_cnt_d   = bit_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          shift_reg_d = in_data;
          bit_cnt_d   = '0;
          state_d     = S_SHIFT;
        end
      end

      S_SHIFT: begin
        if (at_last) begin
          // Refill from hold first; a fresh accept is impossible while hold is full.
          bit_cnt_d = '0;
          if (hold_full_q) begin
            shift_reg_d = hold_q;
            hold_full_d = 1'b0;
          end else if (accept) begin
            shift_reg_d = in_data;
          end else begin
            shift_reg_d = shifted;
            state_d     = S_IDLE;
          end
        end else begin
          shift_reg_d = shifted;
          bit_cnt_d   = bit_cnt_q + CNT_W'(1);
          if (accept) begin
            hold_d      = in_data;
            hold_full_d = 1'b1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ser_valid = (state_q == S_SHIFT);
    word_last = at_last;
    busy      = (state_q == S_SHIFT) || hold_full_q;
    ser_out   = IDLE_BIT;
    if (state_q == S_SHIFT) begin
      ser_out = MSB_FIRST ? shift_reg_q[WIDTH-1] : shift_reg_q[0];
    end
  end

endmodule

// File: tb/tb_word_serializer.sv
// Scoreboard bench: an MSB-first and an LSB-first serializer share one input
// stream; a queue-of-bits model predicts every serial cycle of both.
module tb_word_serializer;

  localparam int WIDTH = 8;

  typedef struct packed {
    logic b;
    logic last;
  } exp_t;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;

  logic m_ready, m_ser, m_valid, m_last, m_busy;
  logic l_ready, l_ser, l_valid, l_last, l_busy;

  exp_t q_msb[$];
  exp_t q_lsb[$];

  int errors = 0;
  int checks = 0;

  logic [15:0] cap_msb;
  logic [15:0] cap_lsb;

  word_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(m_ready), .ser_out(m_ser), .ser_valid(m_valid),
    .word_last(m_last), .busy(m_busy)
  );

  word_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) dut_lsb (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(l_ready), .ser_out(l_ser), .ser_valid(l_valid),
    .word_last(l_last), .busy(l_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // The model: an accepted word becomes WIDTH queued bits; the DUT must show one
  // queued bit per cycle, is busy while any remain, and is ready unless a whole
  // second word is waiting behind the one being shifted.
  always @(negedge clk) begin
    exp_t e;
    bit   m_rdy_model;
    bit   l_rdy_model;
    m_rdy_model = (q_msb.size() <= WIDTH);
    l_rdy_model = (q_lsb.size() <= WIDTH);

    checkOutput("msb_valid", m_valid, q_msb.size() > 0);
    checkOutput("msb_busy", m_busy, q_msb.size() > 0);
    checkOutput("msb_ready", m_ready, m_rdy_model);
    if (q_msb.size() > 0) begin
      e = q_msb.pop_front();
      checkOutput("msb_bit", m_ser, e.b);
      checkOutput("msb_last", m_last, e.last);
    end else begin
      checkOutput("msb_idle_bit", m_ser, 1'b0);
      checkOutput("msb_idle_last", m_last, 1'b0);
    end
    if (m_valid) cap_msb = {cap_msb[14:0], m_ser};

    checkOutput("lsb_valid", l_valid, q_lsb.size() > 0);
    checkOutput("lsb_busy", l_busy, q_lsb.size() > 0);
    checkOutput("lsb_ready", l_ready, l_rdy_model);
    if (q_lsb.size() > 0) begin
      e = q_lsb.pop_front();
      checkOutput("lsb_bit", l_ser, e.b);
      checkOutput("lsb_last", l_last, e.last);
    end else begin
      checkOutput("lsb_idle_bit", l_ser, 1'b1);
      checkOutput("lsb_idle_last", l_last, 1'b0);
    end
    if (l_valid) cap_lsb = {cap_lsb[14:0], l_ser};

    // Inputs are stable from here to the next rising edge, which accepts them.
    if (!rst && in_valid) begin
      if (m_rdy_model)
        for (int i = 0; i < WIDTH; i++)
          q_msb.push_back('{b: in_data[WIDTH-1-i], last: (i == WIDTH-1)});
      if (l_rdy_model)
        for (int i = 0; i < WIDTH; i++)
          q_lsb.push_back('{b: in_data[i], last: (i == WIDTH-1)});
    end
  end

  // Offers one word and returns just after the edge that accepts it.
  task automatic applyStimulus(input logic [WIDTH-1:0] w);
    int waited;
    waited   = 0;
    in_data  = w;
    in_valid = 1'b1;
    @(negedge clk);
    while (!m_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!m_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: got in_ready=0 expected 1 within 100 cycles");
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    cap_msb  = '0;
    cap_lsb  = '0;
    #3;
    checkOutput("reset_ser_valid", m_valid, 1'b0);
    checkOutput("reset_in_ready", m_ready, 1'b1);
    checkOutput("reset_lsb_ser_out", l_ser, 1'b1);
    #24;
    rst = 1'b0;
    idleCycles(2);

    $display("[TB] single word 0x35");
    cap_msb = '0;
    cap_lsb = '0;
    applyStimulus(8'h35);
    idleCycles(12);
    checkOutput("single_msb_stream", cap_msb[7:0], 8'b0011_0101);
    checkOutput("single_lsb_stream", cap_lsb[7:0], 8'b1010_1100);

    $display("[TB] back-to-back 0xD4, 0x35");
    cap_msb = '0;
    cap_lsb = '0;
    applyStimulus(8'hD4);
    applyStimulus(8'h35);
    idleCycles(20);
    checkOutput("b2b_msb_stream", cap_msb, 16'b1101_0100_0011_0101);
    checkOutput("b2b_lsb_stream", cap_lsb, 16'b0010_1011_1010_1100);

    $display("[TB] backpressure, three words");
    applyStimulus(8'hA5);
    applyStimulus(8'h3C);
    applyStimulus(8'hE1);
    idleCycles(30);

    $display("[TB] reset mid-word");
    applyStimulus(8'hFF);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    q_msb.delete();
    q_lsb.delete();
    #1;
    checkOutput("midrst_ser_valid", m_valid, 1'b0);
    checkOutput("midrst_ser_out", m_ser, 1'b0);
    checkOutput("midrst_in_ready", m_ready, 1'b1);
    checkOutput("midrst_busy", m_busy, 1'b0);
    checkOutput("midrst_lsb_ser_out", l_ser, 1'b1);
    #4;
    rst = 1'b0;
    idleCycles(2);
    cap_msb = '0;
    applyStimulus(8'h35);
    idleCycles(12);
    checkOutput("post_rst_stream", cap_msb[7:0], 8'b0011_0101);

    $display("[TB] randomized words");
    for (int n = 0; n < 60; n++) begin
      applyStimulus(WIDTH'($urandom));
      if ($urandom_range(0, 2) == 0) idleCycles($urandom_range(0, 10));
    end
    idleCycles(30);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no completion expected finish before 500000");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
